// File: rtl/vector_op_sequencer.sv
// Vector instruction sequencer: walks element groups LANES at a time, driving masks and strobes.
// Optional VSEQ_PERF_EN adds saturating busy/stall cycle counters.
module vector_op_sequencer #(
  parameter int NUM_ELEMS = 16,
  parameter int LANES     = 4,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             RegW_in,
  input  logic             MemW_in,
  input  logic             MemToReg_in,
  input  logic [2:0]       ALUControl_in,
  input  logic [3:0]       Rd_in,
  input  logic [IDX_W:0]   vlen_in,
  output logic [IDX_W-1:0] elem_idx,
  output logic [LANES-1:0] lane_mask,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       rd_out,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
`ifdef VSEQ_PERF_EN
  ,
  output logic [31:0]      perf_busy_cycles,
  output logic [31:0]      perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_DONE} state_t;

  localparam logic [IDX_W:0] LANES_C = (IDX_W+1)'(LANES);
  localparam logic [IDX_W:0] NUM_C   = (IDX_W+1)'(NUM_ELEMS);

  state_t           r_state, w_next_state;
  logic [IDX_W:0]   r_remaining;
  logic [IDX_W-1:0] r_elem_idx;
  logic             r_regw, r_memw, r_memtoreg;
  logic [2:0]       r_alu;
  logic [3:0]       r_rd;

  logic [IDX_W:0]   w_vlen_clamp;
  logic             w_accept, w_advance, w_last;
  logic [LANES-1:0] w_mask;

  assign w_vlen_clamp = (vlen_in > NUM_C) ? NUM_C : vlen_in;
  assign w_accept     = (r_state == S_IDLE) && instr_valid;
  assign w_advance    = (r_state == S_EXEC) || ((r_state == S_MEM_WAIT) && mem_ack);
  assign w_last       = (r_remaining <= LANES_C);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_mask[i] = ((IDX_W+1)'(i) < r_remaining);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          if (w_vlen_clamp == '0)          w_next_state = S_DONE;
          else if (MemW_in || MemToReg_in) w_next_state = S_MEM_WAIT;
          else                             w_next_state = S_EXEC;
        end
      end
      S_EXEC:     if (w_last) w_next_state = S_DONE;
      S_MEM_WAIT: if (mem_ack && w_last) w_next_state = S_DONE;
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    lane_mask   = '0;
    reg_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_EXEC: begin
        lane_mask = w_mask;
        reg_we    = r_regw;
      end
      S_MEM_WAIT: begin
        lane_mask = w_mask;
        mem_req   = 1'b1;
        mem_we    = r_memw;
        // A load writes back only once the data is returned.
        reg_we    = r_memtoreg && !r_memw && mem_ack;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // The last group leaves elem_idx on its base so it never wraps past the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_elem_idx  <= '0;
      r_regw      <= 1'b0;
      r_memw      <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_alu       <= '0;
      r_rd        <= '0;
    end else if (w_accept) begin
      r_remaining <= w_vlen_clamp;
      r_elem_idx  <= '0;
      r_regw      <= RegW_in;
      r_memw      <= MemW_in;
      r_memtoreg  <= MemToReg_in;
      r_alu       <= ALUControl_in;
      r_rd        <= Rd_in;
    end else if (w_advance) begin
      if (w_last) begin
        r_remaining <= '0;
      end else begin
        r_remaining <= r_remaining - LANES_C;
        r_elem_idx  <= r_elem_idx + IDX_W'(LANES);
      end
    end
  end

  assign elem_idx  = r_elem_idx;
  assign alu_ctrl  = r_alu;
  assign rd_out    = r_rd;
  assign dbg_state = r_state;

`ifdef VSEQ_PERF_EN
  logic [31:0] r_perf_busy, r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == S_MEM_WAIT) && !mem_ack && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_cycles  = r_perf_busy;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer: ALU, store, load, clamping and mid-instruction reset.
module tb_vector_op_sequencer;
  localparam int NUM_ELEMS = 16;
  localparam int LANES     = 4;
  localparam int IDX_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic             RegW_in = 1'b0, MemW_in = 1'b0, MemToReg_in = 1'b0;
  logic [2:0]       ALUControl_in = '0;
  logic [3:0]       Rd_in = '0;
  logic [IDX_W:0]   vlen_in = '0;
  logic [IDX_W-1:0] elem_idx;
  logic [LANES-1:0] lane_mask;
  logic [2:0]       alu_ctrl;
  logic [3:0]       rd_out;
  logic             reg_we, mem_req, mem_we;
  logic             mem_ack = 1'b0;
  logic             busy, done;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  vector_op_sequencer #(.NUM_ELEMS(NUM_ELEMS), .LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .RegW_in(RegW_in), .MemW_in(MemW_in), .MemToReg_in(MemToReg_in),
    .ALUControl_in(ALUControl_in), .Rd_in(Rd_in), .vlen_in(vlen_in),
    .elem_idx(elem_idx), .lane_mask(lane_mask), .alu_ctrl(alu_ctrl), .rd_out(rd_out),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the sample point 2ns after the next rising edge.
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  // Expected {elem_idx, lane_mask} per group, from the clamped vector length.
  task automatic build_exp(input int vlen);
    int rem;
    int idx;
    logic [3:0] m;
    rem = (vlen > NUM_ELEMS) ? NUM_ELEMS : vlen;
    idx = 0;
    exp_q.delete();
    while (rem > 0) begin
      m = (rem >= LANES) ? 4'hF : 4'((1 << rem) - 1);
      exp_q.push_back({4'(idx), m});
      idx += LANES;
      rem -= (rem >= LANES) ? LANES : rem;
    end
  endtask

  task automatic send(input logic regw, input logic memw, input logic m2r,
                      input logic [2:0] alu, input logic [3:0] rd, input logic [4:0] vlen);
    int t;
    t = 0;
    RegW_in = regw; MemW_in = memw; MemToReg_in = m2r;
    ALUControl_in = alu; Rd_in = rd; vlen_in = vlen;
    instr_valid = 1'b1;
    while (!instr_ready && t < 20) begin
      adv();
      t++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    adv();
    instr_valid = 1'b0;
    vlen_in = '0;
  endtask

  task automatic run_alu(input logic [2:0] alu, input logic [3:0] rd, input logic [4:0] vlen,
                         input string tag);
    logic [7:0] e;
    build_exp(int'(vlen));
    send(1'b1, 1'b0, 1'b0, alu, rd, vlen);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_idx"},    32'(elem_idx),  32'(e[7:4]));
      chk({tag, "_mask"},   32'(lane_mask), 32'(e[3:0]));
      chk({tag, "_reg_we"}, 32'(reg_we),    32'd1);
      chk({tag, "_busy"},   32'(busy),      32'd1);
      chk({tag, "_memreq"}, 32'(mem_req),   32'd0);
      chk({tag, "_done"},   32'(done),      32'd0);
      chk({tag, "_alu"},    32'(alu_ctrl),  32'(alu));
      chk({tag, "_rd"},     32'(rd_out),    32'(rd));
      adv();
    end
    chk({tag, "_done_pulse"},  32'(done),        32'd1);
    chk({tag, "_done_busy"},   32'(busy),        32'd1);
    chk({tag, "_done_we"},     32'(reg_we),      32'd0);
    chk({tag, "_done_mask"},   32'(lane_mask),   32'd0);
    chk({tag, "_done_ready"},  32'(instr_ready), 32'd0);
    adv();
    chk({tag, "_post_done"},   32'(done),        32'd0);
    chk({tag, "_post_ready"},  32'(instr_ready), 32'd1);
  endtask

  task automatic run_mem(input logic store, input logic [4:0] vlen, input int wait_n,
                         input string tag);
    logic [7:0] e;
    build_exp(int'(vlen));
    send(1'b0, store, !store, 3'b000, 4'd5, vlen);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < wait_n; k++) begin
        chk({tag, "_wait_req"},  32'(mem_req),   32'd1);
        chk({tag, "_wait_we"},   32'(mem_we),    32'(store));
        chk({tag, "_wait_rwe"},  32'(reg_we),    32'd0);
        chk({tag, "_wait_mask"}, 32'(lane_mask), 32'(e[3:0]));
        chk({tag, "_wait_idx"},  32'(elem_idx),  32'(e[7:4]));
        chk({tag, "_wait_done"}, 32'(done),      32'd0);
        adv();
      end
      mem_ack = 1'b1;
      #1;
      chk({tag, "_ack_req"},  32'(mem_req),   32'd1);
      chk({tag, "_ack_we"},   32'(mem_we),    32'(store));
      chk({tag, "_ack_rwe"},  32'(reg_we),    32'(!store));
      chk({tag, "_ack_mask"}, 32'(lane_mask), 32'(e[3:0]));
      chk({tag, "_ack_idx"},  32'(elem_idx),  32'(e[7:4]));
      adv();
      mem_ack = 1'b0;
      #1;
    end
    chk({tag, "_done_pulse"}, 32'(done),    32'd1);
    chk({tag, "_done_req"},   32'(mem_req), 32'd0);
    chk({tag, "_done_mwe"},   32'(mem_we),  32'd0);
    chk({tag, "_done_rwe"},   32'(reg_we),  32'd0);
    adv();
    chk({tag, "_post_done"},  32'(done),        32'd0);
    chk({tag, "_post_ready"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_done"},  32'(done),        32'd0);
    chk({tag, "_mask"},  32'(lane_mask),   32'd0);
    chk({tag, "_idx"},   32'(elem_idx),    32'd0);
    chk({tag, "_alu"},   32'(alu_ctrl),    32'd0);
    chk({tag, "_rd"},    32'(rd_out),      32'd0);
    chk({tag, "_rwe"},   32'(reg_we),      32'd0);
    chk({tag, "_req"},   32'(mem_req),     32'd0);
    chk({tag, "_mwe"},   32'(mem_we),      32'd0);
    chk({tag, "_state"}, 32'(dbg_state),   32'd0);
  endtask

  initial begin
    #1;
    chk_reset_outputs("reset");
    #11;
    rst_n = 1'b1;
    adv();

    // mem_ack outside a memory request must not disturb an idle sequencer
    mem_ack = 1'b1;
    adv();
    chk("stray_ack_busy",  32'(busy),        32'd0);
    chk("stray_ack_ready", 32'(instr_ready), 32'd1);
    chk("stray_ack_rwe",   32'(reg_we),      32'd0);
    mem_ack = 1'b0;
    adv();

    run_alu(3'b010, 4'd3, 5'd16, "alu16");
    run_alu(3'b001, 4'd7, 5'd6,  "alu6");
    run_mem(1'b1, 5'd8, 2, "st8");
    run_mem(1'b0, 5'd4, 0, "ld4");
    run_mem(1'b0, 5'd0, 0, "ld0");
    run_alu(3'b100, 4'd2, 5'd20, "alu20");
    run_alu(3'b011, 4'd1, 5'd0,  "alu0");

    // reset in the middle of a load
    send(1'b0, 1'b0, 1'b1, 3'b110, 4'd9, 5'd16);
    adv();
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int c = 0; c < 3; c++) begin
      adv();
      chk("midrst_hold_done", 32'(done), 32'd0);
      chk("midrst_hold_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    adv();
    chk("midrst_rel_ready", 32'(instr_ready), 32'd1);
    chk("midrst_rel_done",  32'(done),        32'd0);
    adv();
    chk("midrst_rel_done2", 32'(done),        32'd0);

    run_alu(3'b111, 4'd4, 5'd3, "alu3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
